// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel gradient engine.
package sobel_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } sobel_state_t;

  localparam int BYP_TOP   = 0;
  localparam int BYP_BOT   = 1;
  localparam int BYP_LEFT  = 2;
  localparam int BYP_RIGHT = 3;

  function automatic int grad_w(input int dwidth);
    return dwidth + 3;
  endfunction

endpackage

// File: rtl/sobel_grad_3x3_tap_sum.sv
// One window line: swap out-of-image taps for the centre pixel, then register t0 + 2*t1 + t2.
module sobel_tap_sum
  import sobel_pkg::*;
#(
  parameter int DWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DWIDTH-1:0] t0,
  input  logic [DWIDTH-1:0] t1,
  input  logic [DWIDTH-1:0] t2,
  input  logic [DWIDTH-1:0] ctr,
  input  logic [2:0]        sub,
  output logic [DWIDTH+1:0] sum
);

  logic [DWIDTH-1:0] x0, x1, x2;
  logic [DWIDTH+1:0] sum_next;

  always_comb begin
    x0       = sub[0] ? ctr : t0;
    x1       = sub[1] ? ctr : t1;
    x2       = sub[2] ? ctr : t2;
    sum_next = {2'b00, x0} + {1'b0, x1, 1'b0} + {2'b00, x2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum_next;
    end
  end

endmodule

// File: rtl/sobel_grad_3x3.sv
// Streaming 3x3 Sobel gradient engine, three-stage pipeline with valid/ready on both sides.
// Define SOBEL_MAG_EN to add the L1 magnitude output and threshold flag.
module sobel_grad_3x3
  import sobel_pkg::*;
#(
  parameter int DWIDTH   = 10,
  parameter int MAX_COLS = 2048,
  localparam int CW      = $clog2(MAX_COLS),
  localparam int GW      = grad_w(DWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_sof,
  input  logic                 s_eol,
  input  logic                 s_lrow,
  input  logic [DWIDTH-1:0]    data_a,
  input  logic [DWIDTH-1:0]    data_b,
  input  logic [DWIDTH-1:0]    data_c,
  input  logic [DWIDTH-1:0]    data_d,
  input  logic [DWIDTH-1:0]    data_e,
  input  logic [DWIDTH-1:0]    data_f,
  input  logic [DWIDTH-1:0]    data_g,
  input  logic [DWIDTH-1:0]    data_h,
  input  logic [DWIDTH-1:0]    data_i,
  input  logic [CW-1:0]        img_width,
  input  logic                 edge_sel,
`ifdef SOBEL_MAG_EN
  input  logic [GW-1:0]        thresh,
  output logic [GW-1:0]        m_mag,
  output logic                 m_edge,
`endif
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic signed [GW-1:0] m_gx,
  output logic signed [GW-1:0] m_gy,
  output logic                 err_len,
  output logic                 err_sof
);

  localparam int SW = DWIDTH + 2;

  sobel_state_t state_reg;
  logic [CW-1:0] col_reg, width_reg, cur_col, cur_width;
  logic          first_row_reg, pol_reg;
  logic          en, take, len_bad;
  logic [3:0]    byp;

  assign en      = !m_valid | m_ready;
  assign s_ready = en;
  assign take    = s_valid & en & (s_sof | (state_reg == ST_ACTIVE));

  // A sof beat restarts position tracking on that very beat.
  assign cur_col   = s_sof ? '0 : col_reg;
  assign cur_width = s_sof ? img_width : width_reg;
  assign len_bad   = s_eol & (cur_col != (cur_width - CW'(1)));

  assign byp[BYP_TOP]   = s_sof | first_row_reg;
  assign byp[BYP_BOT]   = s_lrow;
  assign byp[BYP_LEFT]  = (cur_col == '0);
  assign byp[BYP_RIGHT] = s_eol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      col_reg       <= '0;
      width_reg     <= '0;
      first_row_reg <= 1'b0;
      pol_reg       <= 1'b0;
      err_len       <= 1'b0;
      err_sof       <= 1'b0;
    end else if (take) begin
      if (s_sof) begin
        width_reg <= img_width;
        pol_reg   <= edge_sel;
      end
      if (s_sof && state_reg == ST_IDLE) begin
        err_len <= len_bad;
        err_sof <= 1'b0;
      end else begin
        err_len <= err_len | len_bad;
        err_sof <= err_sof | s_sof;
      end
      first_row_reg <= s_eol ? 1'b0 : (s_sof | first_row_reg);
      col_reg       <= s_eol ? '0 : cur_col + CW'(1);
      state_reg     <= (s_eol & s_lrow) ? ST_IDLE : ST_ACTIVE;
    end
  end

  // Stage 1: per-tap substitution masks; corners take the OR of both sides.
  logic sub_a, sub_b, sub_c, sub_d, sub_f, sub_g, sub_h, sub_i;
  assign sub_a = byp[BYP_TOP] | byp[BYP_LEFT];
  assign sub_b = byp[BYP_TOP];
  assign sub_c = byp[BYP_TOP] | byp[BYP_RIGHT];
  assign sub_d = byp[BYP_LEFT];
  assign sub_f = byp[BYP_RIGHT];
  assign sub_g = byp[BYP_BOT] | byp[BYP_LEFT];
  assign sub_h = byp[BYP_BOT];
  assign sub_i = byp[BYP_BOT] | byp[BYP_RIGHT];

  logic [DWIDTH-1:0] line_tap [4][3];
  logic [2:0]        line_sub [4];
  logic [SW-1:0]     line_sum [4];

  always_comb begin
    line_tap[BYP_TOP]   = '{data_a, data_b, data_c};
    line_tap[BYP_BOT]   = '{data_g, data_h, data_i};
    line_tap[BYP_LEFT]  = '{data_a, data_d, data_g};
    line_tap[BYP_RIGHT] = '{data_c, data_f, data_i};
    line_sub[BYP_TOP]   = {sub_c, sub_b, sub_a};
    line_sub[BYP_BOT]   = {sub_i, sub_h, sub_g};
    line_sub[BYP_LEFT]  = {sub_g, sub_d, sub_a};
    line_sub[BYP_RIGHT] = {sub_i, sub_f, sub_c};
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_line
    sobel_tap_sum #(.DWIDTH(DWIDTH)) u_sum (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .t0  (line_tap[gi][0]),
      .t1  (line_tap[gi][1]),
      .t2  (line_tap[gi][2]),
      .ctr (data_e),
      .sub (line_sub[gi]),
      .sum (line_sum[gi])
    );
  end

  logic v1_reg, sof1_reg, eol1_reg, pol1_reg;
  logic v2_reg, sof2_reg, eol2_reg;
  logic signed [GW-1:0] gx_diff, gy_diff, gx2_reg, gy2_reg;

  assign gx_diff = $signed({1'b0, line_sum[BYP_LEFT]}) - $signed({1'b0, line_sum[BYP_RIGHT]});
  assign gy_diff = $signed({1'b0, line_sum[BYP_TOP]})  - $signed({1'b0, line_sum[BYP_BOT]});

`ifdef SOBEL_MAG_EN
  logic [GW-1:0] abs_gx, abs_gy, mag_next;
  assign abs_gx   = gx2_reg[GW-1] ? GW'(-gx2_reg) : GW'(gx2_reg);
  assign abs_gy   = gy2_reg[GW-1] ? GW'(-gy2_reg) : GW'(gy2_reg);
  assign mag_next = abs_gx + abs_gy;
`endif

  // Stages 1-3 control plus stage 2 differences and stage 3 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg   <= 1'b0;
      sof1_reg <= 1'b0;
      eol1_reg <= 1'b0;
      pol1_reg <= 1'b0;
      v2_reg   <= 1'b0;
      sof2_reg <= 1'b0;
      eol2_reg <= 1'b0;
      gx2_reg  <= '0;
      gy2_reg  <= '0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
      m_gx     <= '0;
      m_gy     <= '0;
`ifdef SOBEL_MAG_EN
      m_mag    <= '0;
      m_edge   <= 1'b0;
`endif
    end else if (en) begin
      v1_reg   <= take;
      sof1_reg <= s_sof;
      eol1_reg <= s_eol;
      pol1_reg <= s_sof ? edge_sel : pol_reg;
      v2_reg   <= v1_reg;
      sof2_reg <= sof1_reg;
      eol2_reg <= eol1_reg;
      gx2_reg  <= pol1_reg ? -gx_diff : gx_diff;
      gy2_reg  <= pol1_reg ? -gy_diff : gy_diff;
      m_valid  <= v2_reg;
      m_sof    <= sof2_reg;
      m_eol    <= eol2_reg;
      m_gx     <= gx2_reg;
      m_gy     <= gy2_reg;
`ifdef SOBEL_MAG_EN
      m_mag    <= mag_next;
      m_edge   <= mag_next > thresh;
`endif
    end
  end

endmodule

// File: tb/tb_sobel_grad_3x3.sv
// Scoreboard bench for sobel_grad_3x3 (DWIDTH=8); optional SOBEL_MAG_EN outputs checked when defined.
module tb_sobel_grad_3x3;

  localparam int DW = 8;
  localparam int CW = 11;
  localparam int GW = 11;

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_sof, s_eol, s_lrow, edge_sel, m_ready;
  logic [DW-1:0] data_a, data_b, data_c, data_d, data_e, data_f, data_g, data_h, data_i;
  logic [CW-1:0] img_width;
  logic m_valid, m_sof, m_eol, err_len, err_sof;
  logic signed [GW-1:0] m_gx, m_gy;
`ifdef SOBEL_MAG_EN
  logic [GW-1:0] thresh, m_mag;
  logic m_edge;
`endif

  always #5 clk = ~clk;

  sobel_grad_3x3 #(.DWIDTH(DW), .MAX_COLS(2048)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof), .s_eol(s_eol), .s_lrow(s_lrow),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d), .data_e(data_e),
    .data_f(data_f), .data_g(data_g), .data_h(data_h), .data_i(data_i),
    .img_width(img_width), .edge_sel(edge_sel),
`ifdef SOBEL_MAG_EN
    .thresh(thresh), .m_mag(m_mag), .m_edge(m_edge),
`endif
    .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
    .m_gx(m_gx), .m_gy(m_gy), .err_len(err_len), .err_sof(err_sof)
  );

  typedef struct {
    int gx;
    int gy;
    bit sof;
    bit eol;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int img [4][4];

  function automatic int px(int r, int c, int dr, int dc, int rows, int cols);
    int rr, cc;
    rr = r + dr;
    cc = c + dc;
    if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) return img[r][c];
    return img[rr][cc];
  endfunction

  // Out-of-image taps get random junk so substitution is exercised.
  function automatic logic [DW-1:0] win(int r, int c, int dr, int dc, int rows, int cols);
    int rr, cc;
    rr = r + dr;
    cc = c + dc;
    if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) return DW'($urandom_range(0, 255));
    return DW'(img[rr][cc]);
  endfunction

  function automatic exp_t model(int r, int c, int rows, int cols, bit pol, bit sof, bit eol);
    exp_t e;
    int a, b, cq, d, f, g, h, i;
    a  = px(r, c, -1, -1, rows, cols);
    b  = px(r, c, -1,  0, rows, cols);
    cq = px(r, c, -1,  1, rows, cols);
    d  = px(r, c,  0, -1, rows, cols);
    f  = px(r, c,  0,  1, rows, cols);
    g  = px(r, c,  1, -1, rows, cols);
    h  = px(r, c,  1,  0, rows, cols);
    i  = px(r, c,  1,  1, rows, cols);
    e.gy  = (a + 2*b + cq) - (g + 2*h + i);
    e.gx  = (a + 2*d + g) - (cq + 2*f + i);
    if (pol) begin
      e.gx = -e.gx;
      e.gy = -e.gy;
    end
    e.sof = sof;
    e.eol = eol;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin : mon
      exp_t e;
      checks++;
      out_count++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output gx=%0d gy=%0d sof=%0b eol=%0b", m_gx, m_gy, m_sof, m_eol);
      end else begin
        e = sb_q.pop_front();
        $display("out gx=%0d gy=%0d sof=%0b eol=%0b", m_gx, m_gy, m_sof, m_eol);
        if (m_gx !== GW'(e.gx) || m_gy !== GW'(e.gy) || m_sof !== e.sof || m_eol !== e.eol) begin
          errors++;
          $display("FAIL pixel got gx=%0d gy=%0d sof=%0b eol=%0b want gx=%0d gy=%0d sof=%0b eol=%0b",
                   m_gx, m_gy, m_sof, m_eol, e.gx, e.gy, e.sof, e.eol);
        end
`ifdef SOBEL_MAG_EN
        begin : magchk
          int mag;
          mag = (e.gx < 0 ? -e.gx : e.gx) + (e.gy < 0 ? -e.gy : e.gy);
          checks++;
          if (m_mag !== GW'(mag) || m_edge !== (mag > int'(thresh))) begin
            errors++;
            $display("FAIL magnitude got mag=%0d edge=%0b want mag=%0d edge=%0b",
                     m_mag, m_edge, mag, (mag > int'(thresh)));
          end
        end
`endif
      end
    end
  end

  task automatic send_px(input int r, input int c, input int rows, input int cols,
                         input bit sof, input bit es, input bit pol, input bit produce);
    int guard;
    data_a = win(r, c, -1, -1, rows, cols);
    data_b = win(r, c, -1,  0, rows, cols);
    data_c = win(r, c, -1,  1, rows, cols);
    data_d = win(r, c,  0, -1, rows, cols);
    data_e = win(r, c,  0,  0, rows, cols);
    data_f = win(r, c,  0,  1, rows, cols);
    data_g = win(r, c,  1, -1, rows, cols);
    data_h = win(r, c,  1,  0, rows, cols);
    data_i = win(r, c,  1,  1, rows, cols);
    s_sof = sof;
    s_eol = (c == cols - 1);
    s_lrow = (r == rows - 1);
    edge_sel = es;
    s_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got s_ready=%0b want 1", s_ready);
    end else if (produce) begin
      sb_q.push_back(model(r, c, rows, cols, pol, sof, (c == cols - 1)));
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    s_eol = 1'b0;
    s_lrow = 1'b0;
  endtask

  task automatic send_frame(input int rows, input int cols, input bit pol, input bit toggle);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        send_px(r, c, rows, cols, (r == 0 && c == 0),
                (r == 0 && c == 0) ? pol : (toggle ? !pol : pol), pol, 1'b1);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", sb_q.size());
    end
  endtask

  task automatic fill_uniform(input int v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = v;
  endtask

  task automatic fill_stripes();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = (c < 2) ? 0 : 255;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_lrow = 1'b0; edge_sel = 1'b0;
    m_ready = 1'b1;
    img_width = CW'(4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake got m_valid=%0b s_ready=%0b want 0 1", m_valid, s_ready);
    end
    checks++;
    if (m_gx !== '0 || m_gy !== '0 || m_sof !== 1'b0 || m_eol !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got gx=%0d gy=%0d sof=%0b eol=%0b want 0 0 0 0", m_gx, m_gy, m_sof, m_eol);
    end
    checks++;
    if (err_len !== 1'b0 || err_sof !== 1'b0) begin
      errors++;
      $display("FAIL reset_errors got err_len=%0b err_sof=%0b want 0 0", err_len, err_sof);
    end
  endtask

  task automatic test_latency();
    int k;
    fill_uniform(100);
    img_width = CW'(1);
    send_px(0, 0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    k = 1;
    while (k < 10) begin
      @(negedge clk);
      if (m_valid) break;
      @(posedge clk);
      k++;
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL latency got %0d want 3", k);
    end
    drain();
  endtask

  task automatic test_uniform();
    int start;
    fill_uniform(100);
    img_width = CW'(4);
    start = out_count;
    send_frame(4, 4, 1'b0, 1'b0);
    drain();
    checks++;
    if (out_count - start != 16 || err_len !== 1'b0 || err_sof !== 1'b0) begin
      errors++;
      $display("FAIL uniform got outputs=%0d err_len=%0b err_sof=%0b want 16 0 0",
               out_count - start, err_len, err_sof);
    end
  endtask

  task automatic test_stripes();
    fill_stripes();
    img_width = CW'(4);
    send_frame(4, 4, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_polarity();
    fill_stripes();
    img_width = CW'(4);
    send_frame(4, 4, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_stall();
    int start;
    fill_stripes();
    img_width = CW'(4);
    start = out_count;
    fork
      send_frame(4, 4, 1'b0, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got m_valid=%0b s_ready=%0b want 1 0", m_valid, s_ready);
          end else if (sb_q.size() > 0 && (m_gx !== GW'(sb_q[0].gx) || m_sof !== sb_q[0].sof)) begin
            errors++;
            $display("FAIL stall_data got gx=%0d sof=%0b want gx=%0d sof=%0b",
                     m_gx, m_sof, sb_q[0].gx, sb_q[0].sof);
          end
          @(posedge clk);
        end
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (out_count - start != 16) begin
      errors++;
      $display("FAIL stall_count got %0d want 16", out_count - start);
    end
  endtask

  task automatic test_errors();
    fill_stripes();
    img_width = CW'(4);
    send_frame(3, 3, 1'b0, 1'b0);
    drain();
    checks++;
    if (err_len !== 1'b1 || err_sof !== 1'b0) begin
      errors++;
      $display("FAIL err_len_set got err_len=%0b err_sof=%0b want 1 0", err_len, err_sof);
    end
    send_px(0, 0, 4, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_len !== 1'b0) begin
      errors++;
      $display("FAIL err_len_clear got %0b want 0", err_len);
    end
    for (int p = 1; p < 6; p++) send_px(p / 4, p % 4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_sof !== 1'b0) begin
      errors++;
      $display("FAIL err_sof_early got %0b want 0", err_sof);
    end
    send_frame(4, 4, 1'b0, 1'b0);
    drain();
    checks++;
    if (err_sof !== 1'b1 || err_len !== 1'b0) begin
      errors++;
      $display("FAIL err_sof_set got err_sof=%0b err_len=%0b want 1 0", err_sof, err_len);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    fill_stripes();
    img_width = CW'(4);
    for (int p = 0; p < 5; p++) send_px(p / 4, p % 4, 4, 4, (p == 0), 1'b0, 1'b0, 1'b1);
    m_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_ready = 1'b1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid got %0b want 0", m_valid);
    end
    start = out_count;
    for (int c = 0; c < 3; c++) send_px(1, c, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || out_count != start) begin
      errors++;
      $display("FAIL idle_drop got m_valid=%0b outputs=%0d want 0 0", m_valid, out_count - start);
    end
    send_frame(4, 4, 1'b0, 1'b0);
    drain();
    checks++;
    if (out_count - start != 16) begin
      errors++;
      $display("FAIL reset_resume got %0d want 16", out_count - start);
    end
  endtask

  initial begin
`ifdef SOBEL_MAG_EN
    thresh = GW'(500);
`endif
    test_reset();
    test_latency();
    test_uniform();
    test_stripes();
    test_polarity();
    test_stall();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
